task_sequencer: RTL and testbench

- Sequences the line-based rotation/processing engine for each task issued by the camera control FSM.
- Latches deg/mode on each newtask pulse and waits for a frame boundary (vsync).
- Issues one start/done handshake per output line, then flips the ping-pong display bank.
- Drives the busy flag back to the control FSM; that FSM waits on !busy before returning to IDLE or TAKEPHOTO.

---
 rtl/task_seq_pkg.sv | 16 +
 rtl/task_sequencer_watchdog.sv | 39 +++
 rtl/task_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_task_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/task_seq_pkg.sv
// Shared state encoding and field widths for the task sequencer.
package task_seq_pkg;

   localparam int unsigned DEG_W  = 6;
   localparam int unsigned MODE_W = 3;
   localparam logic [DEG_W-1:0] DEG_RST = 6'd6;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_VS,
      ISSUE,
      WAIT_DONE,
      FINISH
   } seq_state_e;

endpackage

// File: rtl/task_sequencer_watchdog.sv
// Per-line watchdog for task_sequencer; only built when TASK_SEQ_WATCHDOG_EN is defined.
// Counts enabled cycles since the last clear and flags when TIMEOUT cycles have elapsed.
`ifdef TASK_SEQ_WATCHDOG_EN
module seq_watchdog
   import task_seq_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expire_o
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Saturate at the limit so a stuck enable never wraps back to zero.
   assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i && !expire_o)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule
`endif

// File: rtl/task_sequencer.sv
// Per-task line sequencer: latches deg/mode, waits for vsync, hands out one line at a time,
// then flips the display bank. Optional per-line watchdog under TASK_SEQ_WATCHDOG_EN.
module task_sequencer
   import task_seq_pkg::*;
#(
   parameter int unsigned LINES   = 480,
   parameter int unsigned LW      = 9,
   parameter int unsigned TIMEOUT = 1048576
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_newtask,
   input  logic [DEG_W-1:0]  i_deg,
   input  logic [MODE_W-1:0] i_mode,
   input  logic              i_vsync,
   input  logic              i_line_done,
   output logic              o_line_start,
   output logic [LW-1:0]     o_line_idx,
   output logic [DEG_W-1:0]  o_deg,
   output logic [MODE_W-1:0] o_mode,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_bank,
   output logic              o_err
);

   seq_state_e        state_q, state_d;
   logic [LW-1:0]     idx_q, idx_d;
   logic [DEG_W-1:0]  deg_q, deg_d, pdeg_q, pdeg_d;
   logic [MODE_W-1:0] mode_q, mode_d, pmode_q, pmode_d;
   logic              pend_q, pend_d;
   logic              busy_q, busy_d;
   logic              ls_q, ls_d;
   logic              fd_q, fd_d;
   logic              bank_q, bank_d;
   logic              vs_q;
   logic              vs_rise;
   logic              exit_frame;
   logic              wd_expire;

   assign vs_rise = i_vsync & ~vs_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      deg_d      = deg_q;
      mode_d     = mode_q;
      pend_d     = pend_q;
      pdeg_d     = pdeg_q;
      pmode_d    = pmode_q;
      exit_frame = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_newtask) begin
               deg_d   = i_deg;
               mode_d  = i_mode;
               state_d = WAIT_VS;
            end
         end
         WAIT_VS: begin
            if (vs_rise) begin
               idx_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (i_line_done) begin
               if (idx_q == LW'(LINES - 1))
                  state_d = FINISH;
               else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = ISSUE;
               end
            end else if (wd_expire)
               exit_frame = 1'b1;
         end
         FINISH: exit_frame = 1'b1;
         default: state_d = IDLE;
      endcase

      // Requests outside IDLE queue up behind the running frame; the newest one wins.
      if (i_newtask && state_q != IDLE) begin
         pend_d  = 1'b1;
         pdeg_d  = i_deg;
         pmode_d = i_mode;
      end

      if (exit_frame) begin
         if (pend_d) begin
            deg_d   = pdeg_d;
            mode_d  = pmode_d;
            pend_d  = 1'b0;
            state_d = WAIT_VS;
         end else
            state_d = IDLE;
      end

      // Outputs are registered from the next state so they line up with the state they describe.
      busy_d = (state_d != IDLE);
      ls_d   = (state_d == ISSUE);
      fd_d   = (state_d == FINISH);
      bank_d = bank_q ^ fd_d;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         deg_q   <= DEG_RST;
         mode_q  <= '0;
         pend_q  <= 1'b0;
         pdeg_q  <= '0;
         pmode_q <= '0;
         busy_q  <= 1'b0;
         ls_q    <= 1'b0;
         fd_q    <= 1'b0;
         bank_q  <= 1'b0;
         vs_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         deg_q   <= deg_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         pdeg_q  <= pdeg_d;
         pmode_q <= pmode_d;
         busy_q  <= busy_d;
         ls_q    <= ls_d;
         fd_q    <= fd_d;
         bank_q  <= bank_d;
         vs_q    <= i_vsync;
      end
   end

`ifdef TASK_SEQ_WATCHDOG_EN
   logic err_q, err_d;

   seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk_i   (i_clk),
      .rst_ni  (i_rst_n),
      .clr_i   (state_q == ISSUE),
      .en_i    (state_q == WAIT_DONE),
      .expire_o(wd_expire)
   );

   // Sticky until the control FSM issues a fresh task from IDLE.
   always_comb begin
      err_d = err_q;
      if (state_q == IDLE && i_newtask)
         err_d = 1'b0;
      else if (state_q == WAIT_DONE && !i_line_done && wd_expire)
         err_d = 1'b1;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         err_q <= 1'b0;
      else
         err_q <= err_d;
   end

   assign o_err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
   assign wd_expire      = 1'b0;
   assign o_err          = 1'b0;
`endif

   assign o_line_start = ls_q;
   assign o_line_idx   = idx_q;
   assign o_deg        = deg_q;
   assign o_mode       = mode_q;
   assign o_busy       = busy_q;
   assign o_frame_done = fd_q;
   assign o_bank       = bank_q;

endmodule

// File: tb/tb_task_sequencer.sv
// Bench for task_sequencer (LINES=4, TIMEOUT=32): cycle table plus scoreboarded multi-frame sequences.
module tb_task_sequencer;

   localparam int unsigned LINES   = 4;
   localparam int unsigned LW      = 3;
   localparam int unsigned TIMEOUT = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          nt = 1'b0;
   logic [5:0]    deg = '0;
   logic [2:0]    mode = '0;
   logic          vs = 1'b0;
   logic          ld = 1'b0;
   logic          o_line_start;
   logic [LW-1:0] o_line_idx;
   logic [5:0]    o_deg;
   logic [2:0]    o_mode;
   logic          o_busy;
   logic          o_frame_done;
   logic          o_bank;
   logic          o_err;

   int n_vec = 0;
   int n_err = 0;
   bit sb_on = 1'b0;

   typedef struct packed {
      logic       nt;
      logic [5:0] deg;
      logic [2:0] mode;
      logic       vs;
      logic       ld;
      logic       e_busy;
      logic       e_ls;
      logic [2:0] e_idx;
      logic       e_fd;
      logic       e_bank;
      logic [5:0] e_deg;
      logic [2:0] e_mode;
   } vec_t;

   typedef struct packed {
      logic [2:0] idx;
      logic [5:0] deg;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[19];

   task_sequencer #(.LINES(LINES), .LW(LW), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_newtask   (nt),
      .i_deg       (deg),
      .i_mode      (mode),
      .i_vsync     (vs),
      .i_line_done (ld),
      .o_line_start(o_line_start),
      .o_line_idx  (o_line_idx),
      .o_deg       (o_deg),
      .o_mode      (o_mode),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done),
      .o_bank      (o_bank),
      .o_err       (o_err)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input int a_nt, input int a_deg, input int a_mode, input int a_vs,
                               input int a_ld, input int b_busy, input int b_ls, input int b_idx,
                               input int b_fd, input int b_bank, input int b_deg, input int b_mode);
      vec_t v;
      v.nt = 1'(a_nt);      v.deg = 6'(a_deg);    v.mode = 3'(a_mode);
      v.vs = 1'(a_vs);      v.ld = 1'(a_ld);
      v.e_busy = 1'(b_busy); v.e_ls = 1'(b_ls);   v.e_idx = 3'(b_idx);
      v.e_fd = 1'(b_fd);    v.e_bank = 1'(b_bank); v.e_deg = 6'(b_deg); v.e_mode = 3'(b_mode);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input int idx, input int d);
      exp_t e;
      e.idx = 3'(idx);
      e.deg = 6'(d);
      sb.push_back(e);
   endtask

   // Engine model: answer each line start three cycles later, from ISSUE of line 0 to FINISH.
   task automatic run_lines(input int d);
      for (int i = 0; i < int'(LINES); i++) begin
         step();
         step();
         if (i < int'(LINES) - 1) sb_push(i + 1, d);
         ld = 1'b1;
         step();
         ld = 1'b0;
      end
   endtask

   // Every line start must match the oldest expectation queued by the stimulus.
   always @(posedge clk) begin
      #1;
      if (sb_on && rst_n && o_line_start) begin
         n_vec++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_start: got unexpected start idx=%0d deg=%0d, expected none", o_line_idx, o_deg);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (o_line_idx !== e.idx || o_deg !== e.deg) begin
               n_err++;
               $display("FAIL sb_start: got idx=%0d deg=%0d, expected idx=%0d deg=%0d",
                        o_line_idx, o_deg, e.idx, e.deg);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   cyc;
      logic bank0;
      logic saw_fd;

      //          nt deg md vs ld | busy ls idx fd bank deg md
      tbl[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 6, 0);
      tbl[1]  = mk(1, 10, 3, 1, 0,  1, 0, 0, 0, 0, 10, 3);
      tbl[2]  = mk(0, 0, 0, 1, 1,   1, 0, 0, 0, 0, 10, 3);
      tbl[3]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 10, 3);
      tbl[4]  = mk(0, 0, 0, 1, 0,   1, 1, 0, 0, 0, 10, 3);
      tbl[5]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 10, 3);
      tbl[6]  = mk(0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 10, 3);
      tbl[7]  = mk(0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 10, 3);
      tbl[8]  = mk(0, 0, 0, 0, 1,   1, 0, 1, 0, 0, 10, 3);
      tbl[9]  = mk(0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 10, 3);
      tbl[10] = mk(0, 0, 0, 0, 1,   1, 1, 2, 0, 0, 10, 3);
      tbl[11] = mk(0, 0, 0, 0, 0,   1, 0, 2, 0, 0, 10, 3);
      tbl[12] = mk(0, 0, 0, 0, 0,   1, 0, 2, 0, 0, 10, 3);
      tbl[13] = mk(0, 0, 0, 0, 1,   1, 1, 3, 0, 0, 10, 3);
      tbl[14] = mk(0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 10, 3);
      tbl[15] = mk(0, 0, 0, 0, 0,   1, 0, 3, 0, 0, 10, 3);
      tbl[16] = mk(0, 0, 0, 0, 1,   1, 0, 3, 1, 1, 10, 3);
      tbl[17] = mk(0, 0, 0, 0, 0,   0, 0, 3, 0, 1, 10, 3);
      tbl[18] = mk(0, 0, 0, 0, 1,   0, 0, 3, 0, 1, 10, 3);

      #12;
      chk("reset_state", {o_busy, o_line_start, 5'(o_line_idx), o_frame_done, o_bank, o_err, o_deg, o_mode},
          {1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd6, 3'd0});
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         nt = tbl[i].nt; deg = tbl[i].deg; mode = tbl[i].mode; vs = tbl[i].vs; ld = tbl[i].ld;
         step();
         chk($sformatf("vec%0d", i),
             {o_busy, o_line_start, 5'(o_line_idx), o_frame_done, o_bank, o_deg, o_mode},
             {tbl[i].e_busy, tbl[i].e_ls, 5'(tbl[i].e_idx), tbl[i].e_fd, tbl[i].e_bank,
              tbl[i].e_deg, tbl[i].e_mode});
      end
      nt = 1'b0; vs = 1'b0; ld = 1'b0;

      // Two requests during the line-1 wait: the frame finishes untouched, the latest one runs next.
      sb_on = 1'b1;
      nt = 1'b1; deg = 6'd10; mode = 3'd3; step(); nt = 1'b0;
      chk("t2_busy", o_busy, 1);
      step();
      sb_push(0, 10); vs = 1'b1; step(); vs = 1'b0;
      step(); step(); sb_push(1, 10); ld = 1'b1; step(); ld = 1'b0;
      step();
      nt = 1'b1; deg = 6'd20; mode = 3'd1; step();
      deg = 6'd21; mode = 3'd0; step(); nt = 1'b0;
      chk("t2_deg_held", o_deg, 10);
      sb_push(2, 10); ld = 1'b1; step(); ld = 1'b0;
      step(); step(); sb_push(3, 10); ld = 1'b1; step(); ld = 1'b0;
      step(); step(); ld = 1'b1; step(); ld = 1'b0;
      chk("t2_finish", {o_frame_done, o_bank, o_busy, o_deg}, {1'b1, 1'b0, 1'b1, 6'd10});
      step();
      chk("t2_pending_loaded", {o_busy, o_frame_done, o_deg, o_mode}, {1'b1, 1'b0, 6'd21, 3'd0});
      step(); step();
      chk("t2_wait_vsync", {o_busy, o_line_start}, 2'b10);
      sb_push(0, 21); vs = 1'b1; step(); vs = 1'b0;
      run_lines(21);
      chk("t2_finish2", {o_frame_done, o_bank, o_mode}, {1'b1, 1'b1, 3'd0});
      step();
      chk("t2_idle", o_busy, 0);
      chk("t2_sb_drained", sb.size(), 0);

      // Reset mid-frame with a request pending: outputs clear at once and the request is lost.
      nt = 1'b1; deg = 6'd5; mode = 3'd0; step(); nt = 1'b0; step();
      sb_push(0, 5); vs = 1'b1; step(); vs = 1'b0;
      step(); step(); sb_push(1, 5); ld = 1'b1; step(); ld = 1'b0;
      step(); step(); sb_push(2, 5); ld = 1'b1; step(); ld = 1'b0;
      nt = 1'b1; deg = 6'd33; mode = 3'd7; step(); nt = 1'b0;
      chk("t3_idx_before_reset", o_line_idx, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("t3_reset_async", {o_busy, o_line_start, 5'(o_line_idx), o_frame_done, o_bank, o_err, o_deg, o_mode},
          {1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 6'd6, 3'd0});
      rst_n = 1'b1;
      step(); vs = 1'b1; step(); vs = 1'b0; step(); step();
      chk("t3_pending_cleared", {o_busy, o_line_start, o_deg}, {1'b0, 1'b0, 6'd6});
      chk("t3_sb_drained", sb.size(), 0);

`ifdef TASK_SEQ_WATCHDOG_EN
      // Withheld line_done: the watchdog ends the task with no frame_done and no bank flip.
      bank0 = o_bank;
      saw_fd = 1'b0;
      nt = 1'b1; deg = 6'd7; mode = 3'd1; step(); nt = 1'b0; step();
      sb_push(0, 7); vs = 1'b1; step(); vs = 1'b0;
      cyc = 0;
      while (!o_err && cyc < 60) begin
         step();
         cyc++;
         if (o_frame_done) saw_fd = 1'b1;
      end
      chk("wd_err", o_err, 1);
      chk("wd_latency", (cyc >= 32 && cyc <= 34), 1);
      chk("wd_exit", {o_busy, o_bank, saw_fd}, {1'b0, bank0, 1'b0});
      nt = 1'b1; deg = 6'd8; mode = 3'd2; step(); nt = 1'b0;
      chk("wd_err_clear", {o_err, o_busy}, 2'b01);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
